// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared port indices, state encoding and default widths for
// the SRAM arbiter (ram_arbiter and ram_arb_pick).
package ram_arb_pkg;

    localparam int RAM_ARB_ADDR_W = 20;
    localparam int RAM_ARB_DATA_W = 32;
    localparam int NUM_PORTS      = 3;

    localparam logic [1:0] PORT_VGA  = 2'd0;
    localparam logic [1:0] PORT_CAM  = 2'd1;
    localparam logic [1:0] PORT_HOST = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    // Index 3 shifts out and yields an all-zero vector, which keeps ack one-hot or zero.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select. VGA has fixed top priority and
// camera/host alternate according to the round-robin preference bit.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 prefer_host,
    output logic [1:0]           win_id,
    output logic                 win_valid
);

    always_comb begin
        win_id    = PORT_VGA;
        win_valid = |req;
        if (req[PORT_VGA]) begin
            win_id = PORT_VGA;
        end else if (req[PORT_CAM] && (!prefer_host || !req[PORT_HOST])) begin
            win_id = PORT_CAM;
        end else if (req[PORT_HOST]) begin
            win_id = PORT_HOST;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SRAM controller between VGA, camera and host ports.
// Optional BUSY watchdog enabled with `define RAM_ARB_WATCHDOG_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W  = RAM_ARB_ADDR_W,
    parameter int DATA_W  = RAM_ARB_DATA_W
`ifdef RAM_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [1:0]                  grant_id,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_workdone,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        timeout_err
);

    arb_state_e            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [NUM_PORTS-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  prefer_host_q, prefer_host_d;
    logic [1:0]            win_id;
    logic                  win_valid;

`ifdef RAM_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;
`endif

    ram_arb_pick u_pick (
        .req         (req),
        .prefer_host (prefer_host_q),
        .win_id      (win_id),
        .win_valid   (win_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            ack_q         <= '0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            prefer_host_q <= 1'b0;
`ifdef RAM_ARB_WATCHDOG_EN
            wd_cnt_q      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_q        <= read_d;
            write_q       <= write_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            busy_q        <= busy_d;
            prefer_host_q <= prefer_host_d;
`ifdef RAM_ARB_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    // All outputs are registered, so every next value is computed here and
    // presented one cycle after the condition that produced it.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_d        = read_q;
        write_d       = write_q;
        ack_d         = '0;
        rdata_d       = rdata_q;
        busy_d        = busy_q;
        prefer_host_d = prefer_host_q;
`ifdef RAM_ARB_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_id;
                    we_d    = req_we[win_id];
                    addr_d  = req_addr[win_id*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[win_id*DATA_W +: DATA_W];
                    read_d  = !req_we[win_id];
                    write_d = req_we[win_id];
                    busy_d  = 1'b1;
                    state_d = BUSY;
                    if (win_id == PORT_CAM) begin
                        prefer_host_d = 1'b1;
                    end else if (win_id == PORT_HOST) begin
                        prefer_host_d = 1'b0;
                    end
`ifdef RAM_ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_workdone) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ack_d   = port_onehot(grant_q);
                    state_d = RECOVER;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
`ifdef RAM_ARB_WATCHDOG_EN
                end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    ack_d     = port_onehot(grant_q);
                    timeout_d = 1'b1;
                    state_d   = RECOVER;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
`endif
                end
            end
            RECOVER: begin
                // Wait for the controller to drop workdone so a stale level is never
                // mistaken for completion of the next command.
                if (!mem_workdone) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign mem_read  = read_q;
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef RAM_ARB_WATCHDOG_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
